// File: rtl/mips_pkg.sv
// Shared MIPS control-transfer encodings, next-PC select codes and the
// decoded-transfer record passed from the decoder to the redirect controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_REG    = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  typedef struct packed {
    logic        is_branch;
    logic        taken;
    logic [1:0]  pcsrc;
    logic [31:0] target;
    logic        is_link;
    logic [4:0]  link_reg;
  } xfer_t;

endpackage

// File: rtl/ctrl_xfer_decode.sv
// Combinational decode of the ID instruction: classifies BEQ/BNE/J/JAL/JR/JALR,
// resolves the branch condition and picks the matching target.
module ctrl_xfer_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output xfer_t       xfer
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign br_tgt  = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], instr[25:0], 2'b00};

  always_comb begin
    xfer = '0;
    unique case (opcode)
      OP_BEQ, OP_BNE: begin
        xfer.is_branch = 1'b1;
        xfer.taken     = (opcode == OP_BEQ) ? (rs == rt) : (rs != rt);
        xfer.pcsrc     = PCSRC_BRANCH;
        xfer.target    = br_tgt;
      end
      OP_J, OP_JAL: begin
        xfer.taken    = 1'b1;
        xfer.pcsrc    = PCSRC_JUMP;
        xfer.target   = jmp_tgt;
        xfer.is_link  = (opcode == OP_JAL);
        xfer.link_reg = REG_RA;
      end
      OP_RTYPE: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          xfer.taken    = 1'b1;
          xfer.pcsrc    = PCSRC_REG;
          xfer.target   = rs;
          xfer.is_link  = (funct == FN_JALR);
          xfer.link_reg = instr[15:11];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Decode-stage redirect controller: registers a one-cycle next-PC redirect with
// IF/ID flushes, the JAL/JALR link write and branch statistics.
module pc_redirect_ctrl
  import mips_pkg::*;
#(
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc4,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [1:0]       pcsrc,
  output logic [31:0]      branch_target,
  output logic [31:0]      register_target,
  output logic [31:0]      jump_target,
  output logic             flush_if,
  output logic             flush_id,
  output logic             link_we,
  output logic [4:0]       link_reg,
  output logic [31:0]      link_data,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  xfer_t xfer;

  ctrl_xfer_decode u_dec (
    .instr (id_instr),
    .pc4   (id_pc4),
    .rs    (rs_data),
    .rt    (rt_data),
    .xfer  (xfer)
  );

  state_e           state_q, state_d;
  logic [1:0]       pcsrc_q, pcsrc_d;
  logic [31:0]      br_tgt_q, br_tgt_d;
  logic [31:0]      reg_tgt_q, reg_tgt_d;
  logic [31:0]      jmp_tgt_q, jmp_tgt_d;
  logic             flush_if_q, flush_if_d;
  logic             flush_id_q, flush_id_d;
  logic             link_we_q, link_we_d;
  logic [4:0]       link_reg_q, link_reg_d;
  logic [31:0]      link_data_q, link_data_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             accept;

  // The instruction sitting in ID during REDIRECT is never decoded.
  assign accept = (state_q == ST_IDLE) && id_valid && !stall;

  always_comb begin
    state_d      = state_q;
    pcsrc_d      = pcsrc_q;
    br_tgt_d     = br_tgt_q;
    reg_tgt_d    = reg_tgt_q;
    jmp_tgt_d    = jmp_tgt_q;
    flush_if_d   = flush_if_q;
    flush_id_d   = flush_id_q;
    link_we_d    = 1'b0;
    link_reg_d   = link_reg_q;
    link_data_d  = link_data_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        pcsrc_d    = PCSRC_SEQ;
        flush_if_d = 1'b0;
        flush_id_d = 1'b0;
        if (accept) begin
          if (xfer.is_branch) branch_cnt_d = branch_cnt_q + CNT_W'(1);
          if (xfer.taken) begin
            state_d     = ST_REDIRECT;
            pcsrc_d     = xfer.pcsrc;
            flush_if_d  = 1'b1;
            flush_id_d  = (DELAY_SLOT == 0);
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
            unique case (xfer.pcsrc)
              PCSRC_BRANCH: br_tgt_d  = xfer.target;
              PCSRC_REG:    reg_tgt_d = xfer.target;
              PCSRC_JUMP:   jmp_tgt_d = xfer.target;
              default: ;
            endcase
          end
          if (xfer.is_link) begin
            link_we_d   = 1'b1;
            link_reg_d  = xfer.link_reg;
            link_data_d = (DELAY_SLOT != 0) ? id_pc4 + 32'd4 : id_pc4;
          end
        end
      end
      ST_REDIRECT: begin
        if (!stall) begin
          state_d    = ST_IDLE;
          pcsrc_d    = PCSRC_SEQ;
          flush_if_d = 1'b0;
          flush_id_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pcsrc_q      <= PCSRC_SEQ;
      br_tgt_q     <= '0;
      reg_tgt_q    <= '0;
      jmp_tgt_q    <= '0;
      flush_if_q   <= 1'b0;
      flush_id_q   <= 1'b0;
      link_we_q    <= 1'b0;
      link_reg_q   <= '0;
      link_data_q  <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pcsrc_q      <= pcsrc_d;
      br_tgt_q     <= br_tgt_d;
      reg_tgt_q    <= reg_tgt_d;
      jmp_tgt_q    <= jmp_tgt_d;
      flush_if_q   <= flush_if_d;
      flush_id_q   <= flush_id_d;
      link_we_q    <= link_we_d;
      link_reg_q   <= link_reg_d;
      link_data_q  <= link_data_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pcsrc           = pcsrc_q;
  assign branch_target   = br_tgt_q;
  assign register_target = reg_tgt_q;
  assign jump_target     = jmp_tgt_q;
  assign flush_if        = flush_if_q;
  assign flush_id        = flush_id_q;
  assign link_we         = link_we_q;
  assign link_reg        = link_reg_q;
  assign link_data       = link_data_q;
  assign branch_cnt      = branch_cnt_q;
  assign taken_cnt       = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench: vector table for single-cycle behaviour on a DELAY_SLOT=0 and
// a DELAY_SLOT=1 instance sharing inputs, plus link/stall/reset sequences.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, id_valid;
  logic [31:0] id_instr, id_pc4, rs_data, rt_data;

  logic [1:0]  pcsrc0, pcsrc1;
  logic [31:0] btgt0, rtgt0, jtgt0, btgt1, rtgt1, jtgt1;
  logic        fif0, fid0, lwe0, fif1, fid1, lwe1;
  logic [4:0]  lreg0, lreg1;
  logic [31:0] ldat0, ldat1;
  logic [31:0] bcnt0, tcnt0, bcnt1, tcnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.DELAY_SLOT(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc4(id_pc4), .rs_data(rs_data), .rt_data(rt_data),
    .pcsrc(pcsrc0), .branch_target(btgt0), .register_target(rtgt0),
    .jump_target(jtgt0), .flush_if(fif0), .flush_id(fid0), .link_we(lwe0),
    .link_reg(lreg0), .link_data(ldat0), .branch_cnt(bcnt0), .taken_cnt(tcnt0)
  );

  pc_redirect_ctrl #(.DELAY_SLOT(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc4(id_pc4), .rs_data(rs_data), .rt_data(rt_data),
    .pcsrc(pcsrc1), .branch_target(btgt1), .register_target(rtgt1),
    .jump_target(jtgt1), .flush_if(fif1), .flush_id(fid1), .link_we(lwe1),
    .link_reg(lreg1), .link_data(ldat1), .branch_cnt(bcnt1), .taken_cnt(tcnt1)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [1:0]  e_pcsrc;
    logic        e_flush;
    logic [31:0] e_bcnt;
    logic [31:0] e_tcnt;
    logic [1:0]  tsel;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc4, input logic [31:0] rs, input logic [31:0] rt);
    stall = s; id_valid = v; id_instr = ins; id_pc4 = pc4; rs_data = rs; rt_data = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"beq_taken",    0, 1, 32'h10220004, 32'h00400010, 5, 5, 2'b01, 1, 1, 1, 2'd1, 32'h00400020};
    vecs[1]  = '{"redir_ignore", 0, 1, 32'h10220004, 32'h00400010, 7, 7, 2'b00, 0, 1, 1, 2'd1, 32'h00400020};
    vecs[2]  = '{"bne_not",      0, 1, 32'h1422FFFE, 32'h00400010, 5, 5, 2'b00, 0, 2, 1, 2'd1, 32'h00400020};
    vecs[3]  = '{"bne_taken",    0, 1, 32'h1422FFFE, 32'h00400010, 5, 6, 2'b01, 1, 3, 2, 2'd1, 32'h00400008};
    vecs[4]  = '{"back_idle",    0, 0, 32'h00000000, 32'h00000000, 0, 0, 2'b00, 0, 3, 2, 2'd0, 32'h0};
    vecs[5]  = '{"invalid_beq",  0, 0, 32'h10220004, 32'h00500000, 1, 1, 2'b00, 0, 3, 2, 2'd1, 32'h00400008};
    vecs[6]  = '{"stall_beq",    1, 1, 32'h10220004, 32'h00500000, 1, 1, 2'b00, 0, 3, 2, 2'd1, 32'h00400008};
    vecs[7]  = '{"addi",         0, 1, 32'h20010005, 32'h00500000, 1, 1, 2'b00, 0, 3, 2, 2'd0, 32'h0};
    vecs[8]  = '{"rtype_add",    0, 1, 32'h00221820, 32'h00500000, 1, 1, 2'b00, 0, 3, 2, 2'd2, 32'h0};
    vecs[9]  = '{"j_taken",      0, 1, 32'h08100040, 32'h00400004, 0, 0, 2'b11, 1, 3, 3, 2'd3, 32'h00400100};
    vecs[10] = '{"j_release",    0, 1, 32'h00000000, 32'h00400008, 0, 0, 2'b00, 0, 3, 3, 2'd3, 32'h00400100};
    vecs[11] = '{"idle_nop",     0, 1, 32'h00000000, 32'h0040000C, 0, 0, 2'b00, 0, 3, 3, 2'd0, 32'h0};

    rst = 1'b1;
    stall = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc4 = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcsrc", 32'(pcsrc0), 0);
    chk("rst_flush", {30'd0, fif0, fid0}, 0);
    chk("rst_targets", btgt0 | rtgt0 | jtgt0, 0);
    chk("rst_link", {26'd0, lwe0, lreg0} | ldat0, 0);
    chk("rst_cnts", bcnt0 | tcnt0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].valid, vecs[i].instr, vecs[i].pc4, vecs[i].rs, vecs[i].rt);
      chk({vecs[i].name, "_pcsrc"}, 32'(pcsrc0), 32'(vecs[i].e_pcsrc));
      chk({vecs[i].name, "_flush_if"}, 32'(fif0), 32'(vecs[i].e_flush));
      chk({vecs[i].name, "_flush_id"}, 32'(fid0), 32'(vecs[i].e_flush));
      chk({vecs[i].name, "_ds_flush_if"}, 32'(fif1), 32'(vecs[i].e_flush));
      chk({vecs[i].name, "_ds_flush_id"}, 32'(fid1), 0);
      chk({vecs[i].name, "_bcnt"}, bcnt0, vecs[i].e_bcnt);
      chk({vecs[i].name, "_tcnt"}, tcnt0, vecs[i].e_tcnt);
      chk({vecs[i].name, "_link_we"}, 32'(lwe0), 0);
      case (vecs[i].tsel)
        2'd1: chk({vecs[i].name, "_btgt"}, btgt0, vecs[i].e_tgt);
        2'd2: chk({vecs[i].name, "_rtgt"}, rtgt0, vecs[i].e_tgt);
        2'd3: chk({vecs[i].name, "_jtgt"}, jtgt0, vecs[i].e_tgt);
        default: ;
      endcase
    end

    // JAL: one-cycle link strobe, return address depends on DELAY_SLOT
    drive(0, 1, 32'h0C100040, 32'h00400004, 0, 0);
    chk("jal_pcsrc", 32'(pcsrc0), 3);
    chk("jal_jtgt", jtgt0, 32'h00400100);
    chk("jal_link_we", 32'(lwe0), 1);
    chk("jal_link_reg", 32'(lreg0), 31);
    chk("jal_link_data", ldat0, 32'h00400004);
    chk("jal_ds_link_data", ldat1, 32'h00400008);
    chk("jal_btgt_kept", btgt0, 32'h00400008);
    chk("jal_tcnt", tcnt0, 4);
    drive(0, 0, 0, 0, 0, 0);
    chk("jal_link_we_off", 32'(lwe0), 0);
    chk("jal_release", 32'(pcsrc0), 0);

    // JALR with two stall cycles during REDIRECT; a J in ID is ignored
    drive(0, 1, 32'h00204809, 32'h00400020, 32'h00401234, 0);
    chk("jalr_pcsrc0", 32'(pcsrc0), 2);
    chk("jalr_rtgt", rtgt0, 32'h00401234);
    chk("jalr_link_we", 32'(lwe0), 1);
    chk("jalr_link_reg", 32'(lreg0), 9);
    chk("jalr_link_data", ldat0, 32'h00400020);
    drive(1, 1, 32'h08000000, 32'h00400024, 0, 0);
    chk("jalr_pcsrc1", 32'(pcsrc0), 2);
    chk("jalr_flush_hold", 32'(fif0), 1);
    chk("jalr_link_we_once", 32'(lwe0), 0);
    drive(1, 1, 32'h08000000, 32'h00400024, 0, 0);
    chk("jalr_pcsrc2", 32'(pcsrc0), 2);
    drive(0, 1, 32'h08000000, 32'h00400024, 0, 0);
    chk("jalr_release", 32'(pcsrc0), 0);
    chk("jalr_flush_off", 32'(fif0), 0);
    chk("jalr_jtgt_kept", jtgt0, 32'h00400100);
    chk("jalr_tcnt", tcnt0, 5);
    chk("jalr_bcnt", bcnt0, 3);

    // Reset while a redirect is in flight
    drive(0, 1, 32'h10220004, 32'h00400010, 5, 5);
    chk("pre_rst_pcsrc", 32'(pcsrc0), 1);
    rst = 1'b1;
    drive(0, 1, 32'h10220004, 32'h00400010, 5, 5);
    chk("mid_rst_pcsrc", 32'(pcsrc0), 0);
    chk("mid_rst_flush", {30'd0, fif0, fid0}, 0);
    chk("mid_rst_cnts", bcnt0 | tcnt0, 0);
    chk("mid_rst_btgt", btgt0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rst_pcsrc", 32'(pcsrc0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Decode-stage control-transfer unit that drives the next-PC select of the fetch stage.
- Inspects the instruction in ID, resolves BEQ/BNE/J/JAL/JR/JALR, and computes the branch, register and jump targets.
- Issues a registered one-cycle redirect (pcsrc plus targets) to the next-PC mux, with matching IF/ID flush controls.
- Also produces the link write for JAL/JALR and branch statistics counters.

Parameters:
- DELAY_SLOT, 0, 1 = the instruction after a control transfer executes (no flush_id); 0 = it is squashed.
- CNT_W, 32, width of the branch/taken statistics counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- stall  input  1  pipeline hazard stall; ID contents are not consumed this cycle
- id_valid  input  1  ID stage holds a real instruction
- id_instr  input  32  instruction in ID
- id_pc4  input  32  address of the ID instruction + 4
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- pcsrc  output  2  00 = pc+4, 01 = branch, 10 = register, 11 = jump
- branch_target  output  32  registered branch destination
- register_target  output  32  registered JR/JALR destination
- jump_target  output  32  registered J/JAL destination
- flush_if  output  1  clear IF/ID at end of this cycle
- flush_id  output  1  turn the current ID instruction into a bubble
- link_we  output  1  link register write strobe
- link_reg  output  5  link destination register
- link_data  output  32  return address
- branch_cnt  output  CNT_W  decoded BEQ/BNE count
- taken_cnt  output  CNT_W  taken control transfers count

Behaviour:
- Reset (synchronous, rst high at posedge) gives:
  - pcsrc = 00; all three targets = 0; flush_if = flush_id = 0; link_we = 0; link_reg = 0; link_data = 0; both counters = 0; state IDLE.
  - Reset overrides any in-flight redirect.
- Decode is on opcode id_instr[31:26]:
  - BEQ 000100 takes when rs_data == rt_data. BNE 000101 takes when they differ.
  - J 000010 and JAL 000011 always take.
  - Opcode 000000 with funct id_instr[5:0] = 001000 is JR; 001001 is JALR. Both always take.
- Target arithmetic, all mod 2^32:
  - branch = id_pc4 + ({{14{imm[15]}}, imm, 2'b00}).
  - jump = {id_pc4[31:28], id_instr[25:0], 2'b00}.
  - register = rs_data.
- "Accept" means state IDLE && id_valid && !stall.
- FSM has two states, IDLE and REDIRECT.
  - IDLE -> REDIRECT on accept of a taken transfer. At that edge, register the pcsrc code and the computed target, and leave the unselected targets unchanged.
  - REDIRECT drives the registered pcsrc and flush_if = 1, with flush_id = !DELAY_SLOT.
  - REDIRECT -> IDLE on the first cycle with stall = 0. While stall = 1, hold all outputs and stay in REDIRECT.
  - In IDLE, pcsrc = 00 and both flushes = 0.
- The ID instruction present during REDIRECT is never decoded (wrong path or delay slot). Resulting latency: transfer in ID at cycle N, pcsrc valid at cycle N+1, target instruction in ID at N+3.
- Link write, registered with the same timing as the redirect (one cycle):
  - Triggered by accept of JAL or JALR.
  - link_reg = 31 for JAL, id_instr[15:11] for JALR.
  - link_data = id_pc4 + 4 if DELAY_SLOT = 1, else id_pc4.
  - link_we is high for exactly one cycle, independent of stall.
- Counters:
  - branch_cnt increments on accept of BEQ/BNE, taken or not.
  - taken_cnt increments on accept of any taken transfer.
  - Both wrap at 2^CNT_W.
- Boundaries:
  - id_valid = 0 or stall = 1 in IDLE: no state change, no counting.
  - A not-taken branch: pcsrc stays 00, branch_cnt increments, no flush.
  - A non-control opcode has no effect.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE/OP_BEQ/OP_BNE/OP_J/OP_JAL and funct constants FN_JR/FN_JALR;
  - the PCSRC_SEQ/BRANCH/REG/JUMP 2-bit codes, shared with the next-PC mux;
  - the REG_RA = 31 constant.
- One combinational sub-module, ctrl_xfer_decode: instr, pc4, rs, rt -> is_branch, taken, pcsrc code, target, is_link, link_reg. pc_redirect_ctrl holds the FSM, registers and counters.

Test Plan:
- BEQ with id_pc4 = 0x00400010, imm = 0x0004, rs = rt = 5 -> next cycle pcsrc = 01, branch_target = 0x00400020, flush_if = 1, flush_id = 1; counters 1/1; pcsrc = 00 the following cycle.
- BNE, imm = 0xFFFE, rs = rt -> pcsrc stays 00, no flush, branch_cnt = 1, taken_cnt = 0. Same with rs != rt and id_pc4 = 0x00400010 -> branch_target = 0x00400008.
- JAL instr = 0x0C100040, id_pc4 = 0x00400004 -> pcsrc = 11, jump_target = 0x00400100, link_we = 1 for one cycle, link_reg = 31, link_data = 0x00400004 (DELAY_SLOT = 0).
- JALR rs_data = 0x00401234, rd = 9, with stall raised in the REDIRECT cycle for 2 cycles -> pcsrc = 10 held 3 cycles, link_we high 1 cycle, the instruction in ID meanwhile is ignored.
- rst asserted during REDIRECT -> next cycle pcsrc = 00, flushes = 0, counters = 0.
- DELAY_SLOT = 1, J taken -> flush_if = 1, flush_id = 0.
